adder_result_stage: RTL and testbench
=====================================

# adder_result_stage

Registered output stage for the 32-bit ripple-carry adder. It takes the adder's combinational sum and carry-out, plus the two operand sign bits, and derives zero, negative and signed-overflow flags. Each result is buffered in a small FIFO with a valid/ready handshake, so the adder's consumer can stall without losing results. The stage also keeps a wrapping count of delivered results and a sticky overflow indicator for status readback.

## Interface
Parameters:
- WIDTH, 32: sum width, in bits.
- DEPTH, 2: FIFO entries. Must be a power of two, minimum 2.
- CNT_W, 16: width of the delivered-result counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- in_valid  in  1  adder result presented this cycle.
- in_ready  out  1  stage can accept a result this cycle.
- in_sum  in  WIDTH  adder sum.
- in_cout  in  1  adder carry-out.
- in_a_msb  in  1  bit WIDTH-1 of operand a.
- in_b_msb  in  1  bit WIDTH-1 of operand b.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head entry.
- out_sum  out  WIDTH  head sum.
- out_cout  out  1  head carry-out.
- out_zero  out  1  head sum == 0.
- out_neg  out  1  head sum MSB.
- out_ovf  out  1  head signed overflow.
- done_cnt  out  CNT_W  results delivered since reset.
- ovf_seen  out  1  sticky: some delivered result had ovf=1.

## Operation
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- Flags are computed combinationally at push and stored with the entry:
  - zero = (in_sum == 0). Carry is ignored, so 0xFFFFFFFF+1 with cout=1 gives zero=1.
  - neg = in_sum[WIDTH-1].
  - ovf = (in_a_msb == in_b_msb) && (in_sum[WIDTH-1] != in_a_msb).
- The FIFO uses read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter of 0..DEPTH.
- Outputs:
  - in_ready = (occupancy != DEPTH). It is a function of registered state only, with no combinational path from out_ready.
  - out_valid = (occupancy != 0).
  - out_* fields show the head entry whenever out_valid=1. When out_valid=0 they hold their last value and are don't-care.
- Simultaneous push and pop:
  - Occupancy is unchanged and both pointers advance.
  - When full, in_ready=0, so a push cannot coincide with a pop in that cycle. The freed slot is offered in the next cycle.
  - When empty, a push and pop cannot coincide because out_valid=0.
- done_cnt increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- ovf_seen sets on a pop whose entry has ovf=1. Only reset clears it.
- in_valid while in_ready=0: the result is not captured, and the upstream must hold it. The stage does not check upstream stability.

## Timing
- Reset (rst_n=0 sampled at a rising edge) sets:
  - occupancy=0 and both pointers=0
  - out_valid=0, in_ready=1
  - done_cnt=0, ovf_seen=0
  - out_sum, out_cout and all flags = 0
- Reset mid-operation discards all entries, with no pop recorded. in_ready=1 from the first cycle after the reset edge.
- Latency: a push at edge N gives out_valid=1 with that data after edge N, for a cut-through latency of 1 cycle.
- Throughput: 1 result per cycle sustained with out_ready held at 1, and with in_ready never dropping.
- With out_ready held at 0, DEPTH pushes fill the stage. in_ready falls after the DEPTH-th push edge.
- Results leave in arrival order. Pointer wrap is invisible at the ports.
- done_cnt and ovf_seen are registered and update on the same edge as the pop.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with in_valid=1 and in_sum=0x1234. Required: out_valid=0, in_ready=1, done_cnt=0, ovf_seen=0 throughout, and no entry captured.
- Single result with flags: push in_sum=0x80000000, cout=1, a_msb=1, b_msb=1 with out_ready=1. Required, the next cycle:
  - out_valid=1 with sum=0x80000000, cout=1
  - zero=0, neg=1, ovf=0
  - done_cnt=1 after the pop edge
- Overflow and zero: push sum=0x80000000 with a_msb=0, b_msb=0, giving ovf=1 and neg=1. Then push sum=0x00000000, cout=1, giving zero=1 and ovf=0. Required: ovf_seen=1 after the first pop and still 1 after the second.
- Backpressure and full: hold out_ready=0 and push 0x1, 0x2, 0x3 back to back. Required:
  - in_ready=0 after the 2nd push, so 0x3 is held upstream.
  - Raise out_ready: 0x1 pops, 0x3 is accepted the cycle after, and the order is 0x1, 0x2, 0x3.
- Streaming with wrap: 10 consecutive pushes 0..9 with out_ready=1. Required: output sequence 0..9, one per cycle, in_ready constantly 1, done_cnt=10.
- Counter wrap and mid-stream reset:
  - Preload by popping 65535 results, then pop one more. Required: done_cnt reads 0.
  - Assert rst_n=0 with 2 entries stored. Required: out_valid=0 and empty on the next cycle.

Source files
------------

// File: rtl/adder_result_stage_if.sv
// Handshake and status bundle for the adder result stage.
// "slave" is the stage's view and "master" is the adder/consumer side's view.
interface adder_result_stage_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic             in_cout;
    logic             in_a_msb;
    logic             in_b_msb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_zero;
    logic             out_neg;
    logic             out_ovf;
    logic [CNT_W-1:0] done_cnt;
    logic             ovf_seen;

    modport slave (
        input  in_valid, in_sum, in_cout, in_a_msb, in_b_msb, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_zero, out_neg, out_ovf,
               done_cnt, ovf_seen
    );

    modport master (
        output in_valid, in_sum, in_cout, in_a_msb, in_b_msb, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_zero, out_neg, out_ovf,
               done_cnt, ovf_seen
    );
endinterface

// File: rtl/adder_result_stage.sv
// Registered adder output stage: derives zero/neg/ovf flags, buffers results in a
// small FIFO with valid/ready, and keeps a delivered-result count and sticky overflow.
module adder_result_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    adder_result_stage_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             zero;
        logic             neg;
        logic             ovf;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           wr_ent;
    entry_t           held;
    entry_t           head;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [OCC_W-1:0] occ;
    logic [CNT_W-1:0] done_q;
    logic             ovf_q;
    logic             push;
    logic             pop;

    always_comb begin
        wr_ent      = '0;
        wr_ent.sum  = bus.in_sum;
        wr_ent.cout = bus.in_cout;
        wr_ent.zero = (bus.in_sum == '0);
        wr_ent.neg  = bus.in_sum[WIDTH-1];
        wr_ent.ovf  = (bus.in_a_msb == bus.in_b_msb) && (bus.in_sum[WIDTH-1] != bus.in_a_msb);
    end

    // in_ready depends only on occupancy, so out_ready never reaches it combinationally.
    assign bus.in_ready  = (occ != FULL);
    assign bus.out_valid = (occ != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // When empty, present the last delivered entry instead of a stale slot.
    assign head         = bus.out_valid ? mem[rptr] : held;
    assign bus.out_sum  = head.sum;
    assign bus.out_cout = head.cout;
    assign bus.out_zero = head.zero;
    assign bus.out_neg  = head.neg;
    assign bus.out_ovf  = head.ovf;
    assign bus.done_cnt = done_q;
    assign bus.ovf_seen = ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            held   <= '0;
            wptr   <= '0;
            rptr   <= '0;
            occ    <= '0;
            done_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                mem[wptr] <= wr_ent;
                wptr      <= wptr + PTR_W'(1);
            end
            if (pop) begin
                held   <= mem[rptr];
                rptr   <= rptr + PTR_W'(1);
                done_q <= done_q + CNT_W'(1);
                ovf_q  <= ovf_q | mem[rptr].ovf;
            end
            if (push && !pop)
                occ <= occ + OCC_W'(1);
            else if (pop && !push)
                occ <= occ - OCC_W'(1);
        end
    end
endmodule

// File: tb/tb_adder_result_stage.sv
// Directed bench for adder_result_stage: flags, backpressure, streaming, counter wrap, reset.
module tb_adder_result_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   total  = 0;
    int   passed = 0;

    adder_result_stage_if #(.WIDTH(32), .CNT_W(16)) bus ();

    adder_result_stage #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] s, input logic c,
                         input logic a, input logic b);
        bus.in_valid = v;
        bus.in_sum   = s;
        bus.in_cout  = c;
        bus.in_a_msb = a;
        bus.in_b_msb = b;
    endtask

    initial begin
        // Reset held for two cycles while upstream presents a result
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h1234, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
            chk("rst_done_cnt", 64'(bus.done_cnt), 64'd0);
            chk("rst_ovf_seen", 64'(bus.ovf_seen), 64'd0);
        end
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rst_nothing_captured", 64'(bus.out_valid), 64'd0);
        chk("rst_out_sum", 64'(bus.out_sum), 64'd0);

        // Single result: 0x80000000, both operands negative -> neg=1, no overflow
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("single_valid", 64'(bus.out_valid), 64'd1);
        chk("single_sum", 64'(bus.out_sum), 64'h8000_0000);
        chk("single_cout", 64'(bus.out_cout), 64'd1);
        chk("single_zero", 64'(bus.out_zero), 64'd0);
        chk("single_neg", 64'(bus.out_neg), 64'd1);
        chk("single_ovf", 64'(bus.out_ovf), 64'd0);
        chk("single_cnt_before_pop", 64'(bus.done_cnt), 64'd0);
        tick();
        chk("single_cnt_after_pop", 64'(bus.done_cnt), 64'd1);
        chk("single_empty", 64'(bus.out_valid), 64'd0);
        chk("single_ovf_seen", 64'(bus.ovf_seen), 64'd0);

        // Positive operands giving a negative sum overflow; then a carry-only zero
        drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ovf_flag", 64'(bus.out_ovf), 64'd1);
        chk("ovf_neg", 64'(bus.out_neg), 64'd1);
        drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("ovf_seen_first", 64'(bus.ovf_seen), 64'd1);
        chk("ovf_cnt", 64'(bus.done_cnt), 64'd2);
        chk("zero_flag", 64'(bus.out_zero), 64'd1);
        chk("zero_cout", 64'(bus.out_cout), 64'd1);
        chk("zero_ovf", 64'(bus.out_ovf), 64'd0);
        chk("zero_neg", 64'(bus.out_neg), 64'd0);
        tick();
        chk("ovf_seen_sticky", 64'(bus.ovf_seen), 64'd1);
        chk("zero_cnt", 64'(bus.done_cnt), 64'd3);

        // Backpressure: two entries fill the stage, the third waits upstream
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("bp_ready_after_1", 64'(bus.in_ready), 64'd1);
        drive(1'b1, 32'h2, 1'b0, 1'b0, 1'b0);
        tick();
        chk("bp_full_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_head_1", 64'(bus.out_sum), 64'h1);
        drive(1'b1, 32'h3, 1'b0, 1'b0, 1'b0);
        tick();
        chk("bp_still_full", 64'(bus.in_ready), 64'd0);
        chk("bp_head_held", 64'(bus.out_sum), 64'h1);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_pop1_next2", 64'(bus.out_sum), 64'h2);
        chk("bp_slot_freed", 64'(bus.in_ready), 64'd1);
        chk("bp_cnt4", 64'(bus.done_cnt), 64'd4);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("bp_head_3", 64'(bus.out_sum), 64'h3);
        chk("bp_cnt5", 64'(bus.done_cnt), 64'd5);
        tick();
        chk("bp_cnt6", 64'(bus.done_cnt), 64'd6);
        chk("bp_empty", 64'(bus.out_valid), 64'd0);

        // Fresh reset, then 10 back-to-back results across pointer wraps
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst2_cnt", 64'(bus.done_cnt), 64'd0);
        chk("rst2_ovf_seen", 64'(bus.ovf_seen), 64'd0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
            chk($sformatf("stream_ready_%0d", i), 64'(bus.in_ready), 64'd1);
            tick();
            chk($sformatf("stream_valid_%0d", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("stream_sum_%0d", i), 64'(bus.out_sum), 64'(i));
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("stream_cnt10", 64'(bus.done_cnt), 64'd10);

        // Counter wrap: 65525 more results reach 65535, one more wraps to 0
        for (int i = 0; i < 65525; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("cnt_max", 64'(bus.done_cnt), 64'd65535);
        drive(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("cnt_wrap", 64'(bus.done_cnt), 64'd0);

        // Set ovf_seen and count one pop, store two entries, then reset mid-stream
        drive(1'b1, 32'h7fff_ffff, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("pre_rst_ovf_seen", 64'(bus.ovf_seen), 64'd1);
        chk("pre_rst_cnt", 64'(bus.done_cnt), 64'd1);
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        tick();
        chk("pre_rst_full", 64'(bus.in_ready), 64'd0);
        chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_ready", 64'(bus.in_ready), 64'd1);
        chk("midrst_cnt", 64'(bus.done_cnt), 64'd0);
        chk("midrst_ovf_seen", 64'(bus.ovf_seen), 64'd0);
        tick();
        chk("midrst_still_empty", 64'(bus.out_valid), 64'd0);
        chk("midrst_no_pop", 64'(bus.done_cnt), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
